// File: rtl/xprog_loader_pkg.sv
// Shared definitions for the program loader: frame constants and FSM state encodings.
// No logic; the helpers classify states for the busy and ready outputs.
package xprog_loader_pkg;

    localparam int         LEN_W          = 16;
    localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_SYNC  = 4'd1,
        ST_LEN_H = 4'd2,
        ST_LEN_L = 4'd3,
        ST_DATA  = 4'd4,
        ST_WRITE = 4'd5,
        ST_CSUM  = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERR   = 4'd8
    } state_t;

    function automatic logic state_is_busy(state_t s);
        return s inside {ST_SYNC, ST_LEN_H, ST_LEN_L, ST_DATA, ST_WRITE, ST_CSUM};
    endfunction

    function automatic logic state_takes_byte(state_t s);
        return s inside {ST_SYNC, ST_LEN_H, ST_LEN_L, ST_DATA, ST_CSUM};
    endfunction

endpackage

// File: rtl/xprog_loader_asm.sv
// Byte-to-word shift assembler, MS byte first; word_nxt/word_done are combinational
// with the final byte so the owner can capture the full word on that edge. No backpressure.
module xprog_loader_asm #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_vld,
    input  logic [7:0]        byte_dat,
    output logic [DATA_W-1:0] word_nxt,
    output logic              word_done
);
    localparam int NBYTES = DATA_W / 8;
    localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BCNT_W-1:0] LAST = BCNT_W'(NBYTES - 1);

    logic [DATA_W-1:0] word_q;
    logic [BCNT_W-1:0] bcnt_q;

    assign word_nxt  = (word_q << 8) | DATA_W'(byte_dat);
    assign word_done = byte_vld && (bcnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            bcnt_q <= '0;
        end else if (clr) begin
            word_q <= '0;
            bcnt_q <= '0;
        end else if (byte_vld) begin
            word_q <= word_nxt;
            bcnt_q <= word_done ? '0 : bcnt_q + BCNT_W'(1);
        end
    end

endmodule

// File: rtl/xprog_loader.sv
// Boot loader: framed byte stream -> sequential program RAM writes with length/checksum check.
// Write lands 1 cycle after a word's last byte; rx_ready drops during WRITE and outside a load.
module xprog_loader
    import xprog_loader_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         ADDR_W    = 9,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              prog_sel,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);
    localparam int LEN_MAX = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   word_cnt_q;
    logic [ADDR_W:0]   word_cnt_inc;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] prog_addr_q;
    logic [DATA_W-1:0] prog_data_q;
    logic              xfer;
    logic              asm_vld;
    logic              asm_done;
    logic [DATA_W-1:0] asm_word;

    // start wins over a coincident byte, so that byte is never consumed
    assign xfer         = rx_valid && rx_ready && !start;
    assign len_full     = {len_q[15:8], rx_data};
    assign word_cnt_inc = word_cnt_q + (ADDR_W+1)'(1);
    assign asm_vld      = xfer && (state_q == ST_DATA);

    xprog_loader_asm #(.DATA_W(DATA_W)) u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start),
        .byte_vld  (asm_vld),
        .byte_dat  (rx_data),
        .word_nxt  (asm_word),
        .word_done (asm_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC:  if (xfer && rx_data == SYNC_BYTE) state_d = ST_LEN_H;
                ST_LEN_H: if (xfer) state_d = ST_LEN_L;
                ST_LEN_L: begin
                    if (xfer) begin
                        if (int'(len_full) > LEN_MAX) state_d = ST_ERR;
                        else if (len_full == '0)      state_d = ST_CSUM;
                        else                          state_d = ST_DATA;
                    end
                end
                ST_DATA:  if (asm_done) state_d = ST_WRITE;
                ST_WRITE: state_d = (LEN_W'(word_cnt_inc) == len_q) ? ST_CSUM : ST_DATA;
                ST_CSUM:  if (xfer) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                default:  state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q       <= '0;
            word_cnt_q  <= '0;
            csum_q      <= '0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else if (start) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            csum_q     <= '0;
        end else begin
            case (state_q)
                ST_LEN_H: if (xfer) begin
                    len_q[15:8] <= rx_data;
                    csum_q      <= csum_q + rx_data;
                end
                ST_LEN_L: if (xfer) begin
                    len_q[7:0] <= rx_data;
                    csum_q     <= csum_q + rx_data;
                end
                ST_DATA: if (xfer) begin
                    csum_q <= csum_q + rx_data;
                    if (asm_done) begin
                        prog_data_q <= asm_word;
                        prog_addr_q <= word_cnt_q[ADDR_W-1:0];
                    end
                end
                ST_WRITE: word_cnt_q <= word_cnt_inc;
                default: ;
            endcase
        end
    end

    assign rx_ready  = state_takes_byte(state_q);
    assign busy      = state_is_busy(state_q);
    assign cpu_hold  = busy;
    assign prog_we   = (state_q == ST_WRITE);
    assign prog_sel  = prog_we;
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);
    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;

endmodule

// File: tb/tb_xprog_loader.sv
// Randomised frame stimulus with a write scoreboard; a negedge monitor checks every RAM write.
`timescale 1ns/1ps
module tb_xprog_loader;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready, prog_sel, prog_we, busy, done, err, cpu_hold;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    xprog_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .prog_sel(prog_sel), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               mon_e;
    logic [DATA_W-1:0] frame_words[$];
    int                n_total = 0;
    int                n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write monitor: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && prog_we) begin
            chk("wr_sel", {63'd0, prog_sel}, 64'd1);
            chk("wr_rx_ready_low", {63'd0, rx_ready}, 64'd0);
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write", prog_addr, prog_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", 64'(prog_addr), 64'(mon_e.addr));
                chk("wr_data", 64'(prog_data), 64'(mon_e.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t;
        t = 0;
        if (stall) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            n_total++;
            $display("FAIL byte_accept_timeout: got rx_ready 0 expected 1 within 200 cycles");
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic pulse_start(input bit with_byte, input logic [7:0] b);
        @(negedge clk);
        start = 1'b1;
        if (with_byte) begin
            rx_valid = 1'b1;
            rx_data  = b;
        end
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic check_result(input bit exp_done, input bit exp_err, input int max_wait);
        int t;
        t = 0;
        @(negedge clk);
        rx_valid = 1'b0;
        while (busy && t < max_wait) begin
            @(negedge clk);
            t++;
        end
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("cpu_hold_end", {63'd0, cpu_hold}, 64'd0);
        chk("done_end", {63'd0, done}, {63'd0, exp_done});
        chk("err_end", {63'd0, err}, {63'd0, exp_err});
        chk("rx_ready_end", {63'd0, rx_ready}, 64'd0);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    // Reference: frame bytes and checksum derived straight from the frame format
    task automatic run_frame(input bit do_start, input int csum_delta, input int ngarb, input bit stall);
        logic [15:0]       len;
        logic [DATA_W-1:0] w;
        logic [7:0]        b;
        int                sum;
        wr_t               e;
        len = 16'(frame_words.size());
        sum = int'(len[15:8]) + int'(len[7:0]);
        if (do_start) pulse_start(1'b0, 8'h00);
        for (int i = 0; i < ngarb; i++) send_byte(8'($urandom_range(0, 8'hA4)), stall);
        send_byte(8'hA5, stall);
        send_byte(len[15:8], stall);
        send_byte(len[7:0], stall);
        for (int i = 0; i < frame_words.size(); i++) begin
            w = frame_words[i];
            e.addr = i;
            e.data = w;
            exp_q.push_back(e);
            for (int k = 0; k < NB; k++) begin
                b = w[DATA_W-1-8*k -: 8];
                sum += int'(b);
                send_byte(b, stall);
            end
        end
        send_byte(8'(sum + csum_delta), stall);
        check_result(csum_delta % 256 == 0, csum_delta % 256 != 0, 20);
    endtask

    initial begin
        #3;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_outputs", 64'({busy, cpu_hold, done, err, rx_ready, prog_we, prog_sel, prog_addr, prog_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rx_ready", {63'd0, rx_ready}, 64'd0);

        // Good two-word frame
        frame_words = '{32'h11223344, 32'hDEADBEEF};
        run_frame(1'b1, 0, 0, 1'b0);

        // Leading garbage, zero length
        pulse_start(1'b0, 8'h00);
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_result(1'b1, 1'b0, 20);

        // Bad checksum: writes still happen
        run_frame(1'b1, 1, 0, 1'b0);

        // Length 513 overflows a 512-word RAM
        pulse_start(1'b0, 8'h00);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h01, 1'b0);
        check_result(1'b0, 1'b1, 0);

        // Same good frame with valid stalls
        frame_words = '{32'h11223344, 32'hDEADBEEF};
        run_frame(1'b1, 0, 0, 1'b1);

        // Abort after two data bytes; restart coincides with a byte that must be dropped
        pulse_start(1'b0, 8'h00);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        pulse_start(1'b1, 8'hA5);
        frame_words = '{32'hCAFEF00D};
        run_frame(1'b0, 0, 0, 1'b0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            frame_words.delete();
            repeat ($urandom_range(1, 6)) frame_words.push_back(DATA_W'($urandom));
            run_frame(1'b1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0,
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Largest legal length fills every address
        frame_words.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) frame_words.push_back(DATA_W'($urandom));
        run_frame(1'b1, 0, 0, 1'b0);

        // Reset mid-load clears outputs within the cycle and issues no write
        pulse_start(1'b0, 8'h00);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        #2;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        chk("midload_rst_outputs",
            64'({busy, cpu_hold, done, err, rx_ready, prog_we, prog_sel, prog_addr, prog_data}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", {63'd0, busy}, 64'd0);

        // Recovery after reset
        frame_words = '{32'h0BADF00D, 32'h12345678, 32'h9ABCDEF0};
        run_frame(1'b1, 0, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xprog_loader.md
Name: xprog_loader

Overview:
- Boot-time program loader that sits directly upstream of the program memory's data-write interface.
- Accepts a framed byte stream from the serial/PS2 receive path and assembles DATA_W-bit instruction words.
- Writes the words sequentially into program RAM, starting at word address 0.
- Checks a length field and an 8-bit checksum, and holds the controller in reset/stall while a load is in progress.

Parameters:
- DATA_W, 32, instruction/data word width; must be a multiple of 8.
- ADDR_W, 9, program RAM word-address width (equals PROG_RAM_ADDR_W).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; arms the loader (aborts any load in progress)
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data is valid
- rx_ready  out  1  loader accepts the byte this cycle
- prog_sel  out  1  program RAM select (to data_sel)
- prog_we  out  1  program RAM write enable (to data_we)
- prog_addr  out  ADDR_W  word address
- prog_data  out  DATA_W  word to write
- busy  out  1  load in progress
- done  out  1  sticky: last load completed with a good checksum
- err  out  1  sticky: last load failed (length overflow or checksum mismatch)
- cpu_hold  out  1  stall request to the controller; equals busy

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0; word counter, byte counter, checksum and length are 0.
- Handshake:
  - A byte transfers when rx_valid & rx_ready are both high on a rising edge.
  - rx_ready is 1 in SYNC, LEN_H, LEN_L, DATA and CSUM; 0 elsewhere.
- Frame format: SYNC_BYTE, LEN[15:8], LEN[7:0], LEN words of DATA_W/8 bytes each (MS byte first), CSUM.
- Checksum: 8-bit wrapping sum of the LEN bytes and all data bytes. SYNC_BYTE and CSUM are excluded.
- States:
  - IDLE: start -> SYNC.
  - SYNC: busy=1. Non-SYNC_BYTE bytes are consumed and discarded. SYNC_BYTE -> LEN_H.
  - LEN_H: latch the high byte -> LEN_L.
  - LEN_L: latch the low byte.
    - LEN > 2^ADDR_W -> ERR.
    - LEN == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: shift each byte into the word register. After the (DATA_W/8)th byte -> WRITE.
  - WRITE:
    - prog_sel=prog_we=1 for exactly one cycle, with prog_addr = word counter and prog_data = assembled word.
    - Word counter then increments.
    - If word counter+1 == LEN -> CSUM; else -> DATA.
  - CSUM: compare the received byte against the accumulated sum. Equal -> DONE; else -> ERR.
  - DONE: done=1, busy=0. Stays until start.
  - ERR: err=1, busy=0. Stays until start.
- prog_sel/prog_we are 0 in every state except WRITE; prog_addr/prog_data hold their last values otherwise.
- Write timing: the first write occurs 1 cycle after the final byte of word 0 is accepted.
- start in any state:
  - Next state SYNC.
  - done, err, counters and checksum cleared.
  - A partially assembled word is dropped and not written.
- start coincident with a byte transfer: the byte is discarded.
- Addressing: prog_addr never wraps. LEN == 2^ADDR_W writes addresses 0..2^ADDR_W-1 and then goes to CSUM.
- rst_n assertion mid-load aborts immediately. No further writes are issued; RAM contents are not restored.

Decomposition:
- Shared package (xprogdefs.vh): SYNC_BYTE value, loader state encodings (IDLE, SYNC, LEN_H, LEN_L, DATA, WRITE, CSUM, DONE, ERR), and LEN field width 16.
- One sub-module: xprog_loader_asm, a byte-to-word shift assembler with byte counter and word-complete flag.
- Checksum and FSM stay in the top module.

Test Plan:
- Good frame: start; A5 00 02 11 22 33 44 DE AD BE EF, CSUM = 8'h02+sum.
  -> Exactly two one-cycle writes: addr 0 = 32'h11223344, addr 1 = 32'hDEADBEEF.
  -> done=1, err=0, busy/cpu_hold low after CSUM.
- Leading garbage + zero length: start; 00 FF A5 00 00 00.
  -> No writes; done=1.
- Bad checksum: same frame as the first case with CSUM+1.
  -> Both writes occur; err=1, done=0.
- Length overflow (ADDR_W=9): A5 02 01.
  -> err=1 immediately after LEN_L; no writes; rx_ready=0.
- rx_valid stalls: toggle rx_valid randomly during the first frame.
  -> Identical writes and result; no byte accepted while rx_ready=0 (WRITE cycles).
- Abort: start again after 2 data bytes, then send a full 1-word frame.
  -> Only the new word is written at addr 0; mid-load rst_n low -> all outputs 0 within the same cycle.
